// File: rtl/wb_ram_arbiter_if.sv
// Per-master Wishbone bundle used to wire a master onto one wb_ram_arbiter port set.
// The master modport faces the master, and the slave modport faces the arbiter.
interface wb_ram_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, adr, dat_w, sel, input  dat_r, ack, err);
    modport slave  (input  cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single-ported RAM bank, one access per 3 cycles.
// Optional macro WB_RAM_ARBITER_ERR_EN turns out-of-range addresses into error responses instead of aliasing.
module wb_ram_arbiter #(
    parameter int AW = 11
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [3:0]  ram_we,
    output logic [31:0] ram_din,
    output logic [14:0] ram_waddr,
    output logic [14:0] ram_raddr,
    output logic        ram_bank_select,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            gnt_q, gnt_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [3:0]      ram_we_q, ram_we_d;
    logic            bank_q, bank_d;

    logic req0, req1;
    logic oor0, oor1;
    logic unused_adr_bits;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_RAM_ARBITER_ERR_EN
    localparam logic [31:0] OOR_MASK = 32'h0001_ffff & ~((32'h1 << (AW + 2)) - 32'h1);
    assign oor0 = |(m0_adr_i & OOR_MASK);
    assign oor1 = |(m1_adr_i & OOR_MASK);
`else
    assign oor0 = 1'b0;
    assign oor1 = 1'b0;
`endif

    // Only adr[AW+1:2] (and the range bits when enabled) are decoded; the rest is deliberately dropped.
    assign unused_adr_bits = ^{m0_adr_i, m1_adr_i};

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        err_d    = err_q;
        ram_we_d = 4'b0000;
        bank_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // NOTE: blocking '=' here, so gnt_d is already the new grant on the next lines.
                    gnt_d    = (req0 & req1) ? ~last_q : req1;
                    last_d   = gnt_d;
                    adr_d    = gnt_d ? m1_adr_i[AW+1:2] : m0_adr_i[AW+1:2];
                    dat_d    = gnt_d ? m1_dat_i : m0_dat_i;
                    sel_d    = gnt_d ? m1_sel_i : m0_sel_i;
                    we_d     = gnt_d ? m1_we_i  : m0_we_i;
                    err_d    = gnt_d ? oor1     : oor0;
                    bank_d   = ~err_d;
                    ram_we_d = (we_d & ~err_d) ? sel_d : 4'b0000;
                    state_d  = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            ram_we_q <= '0;
            bank_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            err_q    <= err_d;
            ram_we_q <= ram_we_d;
            bank_q   <= bank_d;
        end
    end

    assign ram_we          = ram_we_q;
    assign ram_bank_select = bank_q;
    assign ram_din         = dat_q;
    assign ram_waddr       = 15'(adr_q);
    assign ram_raddr       = 15'(adr_q);

    logic in_resp, m0_owns, m1_owns;
    assign in_resp = (state_q == RESP);
    assign m0_owns = in_resp & ~gnt_q;
    assign m1_owns = in_resp &  gnt_q;

    // Ack/err follow the live cyc&stb so a master that abandons its cycle gets no response.
    assign m0_ack_o = m0_owns & req0 & ~err_q;
    assign m1_ack_o = m1_owns & req1 & ~err_q;
    assign m0_dat_o = (m0_owns & ~err_q) ? ram_dout : 32'h0;
    assign m1_dat_o = (m1_owns & ~err_q) ? ram_dout : 32'h0;

`ifdef WB_RAM_ARBITER_ERR_EN
    assign m0_err_o = m0_owns & req0 & err_q;
    assign m1_err_o = m1_owns & req1 & err_q;
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule
